// File: rtl/d_ff.sv
// Single-bit rising-edge D flip-flop with asynchronous active-low clear.
// Wider pipeline registers instantiate one of these per bit.
module d_ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // Storage element: the clear is asynchronous and overrides any clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: a reference model pushes the expected q into a
// scoreboard queue at every stimulus event; entries are popped once q settles.
module tb_d_ff;

  logic clk;
  logic reset;
  logic d;
  logic q;

  logic model_q;
  logic exp_q[$];
  int   tests;
  int   fails;

  d_ff dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (q)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: q=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected value goes in with the stimulus; it is popped after q settles.
  task automatic settle(input string tag);
    logic e;
    exp_q.push_back(model_q);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, q, 1'bx);
    end else begin
      e = exp_q.pop_front();
      check(tag, q, e);
    end
    #4;
  endtask

  task automatic rise(input string tag);
    if (reset) model_q = d;
    else       model_q = 1'b0;
    clk = 1'b1;
    settle(tag);
  endtask

  task automatic fall(input string tag);
    clk = 1'b0;
    settle(tag);
  endtask

  task automatic set_reset(input logic v, input string tag);
    reset = v;
    if (!v) model_q = 1'b0;
    settle(tag);
  endtask

  task automatic set_d(input logic v, input string tag);
    d = v;
    settle(tag);
  endtask

  initial begin
    int rst_left;
    tests   = 0;
    fails   = 0;
    clk     = 1'b0;
    d       = 1'b1;
    reset   = 1'b1;
    model_q = 1'bx;
    #5;

    // Async reset with the clock held low.
    set_reset(1'b0, "async_reset_noclk");
    set_reset(1'b1, "release_no_capture");

    // Capture.
    d = 1'b1; rise("capture_1"); fall("capture_1_fall");
    d = 1'b0; rise("capture_0"); fall("capture_0_fall");

    // Hold: d toggles while clk is low, then a falling edge with d=0.
    d = 1'b1; rise("hold_load_1");
    d = 1'b0; fall("hold_falling_edge");
    set_d(1'b1, "hold_d_toggle_a");
    set_d(1'b0, "hold_d_toggle_b");
    set_d(1'b1, "hold_d_toggle_c");
    set_d(1'b0, "hold_d_toggle_d");
    rise("hold_next_rise"); fall("hold_next_fall");

    // Reset mid-operation, then edges while held in reset.
    d = 1'b1; rise("mid_load_1");
    set_reset(1'b0, "mid_async_clear");
    fall("mid_fall_in_reset");
    rise("in_reset_rise_1"); fall("in_reset_fall_1");
    rise("in_reset_rise_2"); fall("in_reset_fall_2");

    // Release with d=1: no change until the next rising edge.
    set_reset(1'b1, "release_hold_0");
    rise("release_first_capture"); fall("release_first_fall");

    // Random traffic with occasional reset pulses at random phase.
    rst_left = 0;
    for (int i = 0; i < 1000; i++) begin
      d = 1'($urandom_range(0, 1));
      if (rst_left == 0 && reset && $urandom_range(0, 99) < 5) begin
        rst_left = int'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) set_reset(1'b0, "rand_rst_low_phase");
      end
      rise("rand_rise");
      if (rst_left > 0 && reset) set_reset(1'b0, "rand_rst_high_phase");
      fall("rand_fall");
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) set_reset(1'b1, "rand_release");
      end
    end

    if (exp_q.size() != 0) check("scoreboard_drain", 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
